// File: rtl/mdu_sched_if.sv
// -----------------------------------------------------------------------------
// mdu_sched_if
// Bundles the EX-stage multiply/divide request, the D-stage hazard query and
// the HI/LO / busy / stall results exchanged with the MD sequencer.
//   master : EX/hazard side   - drives start, op, a, b, md_req, cancel
//                               observes busy, stall, hi, lo
//   slave  : mdu_sched        - the reverse
// -----------------------------------------------------------------------------
interface mdu_sched_if;
  logic        start;   // EX-stage MD instruction valid this cycle
  logic [2:0]  op;      // 0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6/7 reserved
  logic [31:0] a;       // rs operand
  logic [31:0] b;       // rt operand
  logic        md_req;  // D-stage instruction touches the MD unit / HI / LO
  logic        cancel;  // abort in-flight operation (only with MDU_CANCEL_EN)
  logic        busy;    // operation in progress
  logic        stall;   // stall request to the hazard unit
  logic [31:0] hi;      // HI register
  logic [31:0] lo;      // LO register

  modport master (
    output start, op, a, b, md_req, cancel,
    input  busy, stall, hi, lo
  );

  modport slave (
    input  start, op, a, b, md_req, cancel,
    output busy, stall, hi, lo
  );
endinterface

// File: rtl/mdu_sched.sv
// -----------------------------------------------------------------------------
// mdu_sched
// Multiply/divide sequencer beside the EX-stage ALU. Owns HI/LO, models the
// multi-cycle latency of MULT/MULTU/DIV/DIVU with a 4-bit busy counter and
// raises a combinational stall for a D-stage instruction that needs the unit.
//
// Ports:
//   clk   : core clock, rising edge
//   reset : synchronous, active-high; discards any in-flight result
//   bus   : mdu_sched_if.slave (start/op/a/b/md_req/cancel in,
//           busy/stall/hi/lo out)
//
// Parameters:
//   MULT_CYCLES : busy cycles for MULT/MULTU (1..15)
//   DIV_CYCLES  : busy cycles for DIV/DIVU  (1..15)
//
// Optional feature:
//   MDU_CANCEL_EN : when defined, bus.cancel aborts a running operation and
//                   drops a start issued in the same cycle. When undefined
//                   the cancel input is ignored.
// -----------------------------------------------------------------------------
module mdu_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  mdu_sched_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;        // bit1: divide, bit0: unsigned
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        cancel_s;

  logic [63:0] prod_s;
  logic        a_neg_s, b_neg_s;
  logic [31:0] a_mag_s, b_mag_s, b_safe_s;
  logic [31:0] q_mag_s, r_mag_s;
  logic [31:0] quot_s, rem_s;

`ifdef MDU_CANCEL_EN
  assign cancel_s = bus.cancel;
`else
  logic cancel_unused_s;
  assign cancel_unused_s = bus.cancel;
  assign cancel_s        = 1'b0;
`endif

  // Results computed from the latched operands; only consumed on completion.
  always_comb begin
    prod_s = 64'd0;
    if (op_q[0]) begin
      prod_s = {32'd0, a_q} * {32'd0, b_q};
    end else begin
      prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    end
    // Signed divide works on magnitudes; 0x80000000 / -1 wraps back to
    // 0x80000000 with remainder 0 through the final negation.
    a_neg_s  = (op_q == 2'b10) && a_q[31];
    b_neg_s  = (op_q == 2'b10) && b_q[31];
    a_mag_s  = a_neg_s ? (32'd0 - a_q) : a_q;
    b_mag_s  = b_neg_s ? (32'd0 - b_q) : b_q;
    // Divisor forced nonzero so the datapath never sees x/0; the write is
    // suppressed separately for b == 0.
    b_safe_s = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;
    q_mag_s  = a_mag_s / b_safe_s;
    r_mag_s  = a_mag_s % b_safe_s;
    quot_s   = (a_neg_s ^ b_neg_s) ? (32'd0 - q_mag_s) : q_mag_s;
    rem_s    = a_neg_s ? (32'd0 - r_mag_s) : r_mag_s;
  end

  // Next-state, counter, operand latch and HI/LO update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !cancel_s) begin
          case (bus.op)
            3'd0, 3'd1: begin
              op_d    = bus.op[1:0];
              a_d     = bus.a;
              b_d     = bus.b;
              cnt_d   = MULT_CNT;
              state_d = RUN;
            end
            3'd2, 3'd3: begin
              op_d    = bus.op[1:0];
              a_d     = bus.a;
              b_d     = bus.b;
              cnt_d   = DIV_CNT;
              state_d = RUN;
            end
            3'd4:    hi_d    = bus.a;
            3'd5:    lo_d    = bus.a;
            default: state_d = IDLE;  // reserved opcodes do nothing
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cancel_s) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          if (!op_q[1]) begin
            hi_d = prod_s[63:32];
            lo_d = prod_s[31:0];
          end else if (b_q != 32'd0) begin
            hi_d = rem_s;
            lo_d = quot_s;
          end else begin
            hi_d = hi_q;  // divide by zero leaves HI/LO untouched
            lo_d = lo_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    busy_d = (state_d == RUN);
  end

  // State, counter, operands and outputs; reset discards any pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 2'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  // A start with op 0..3 stalls a dependent D-stage instruction already in
  // the accept cycle, before busy rises.
  assign bus.stall = bus.md_req & (busy_q | (bus.start & (bus.op[2] == 1'b0)));

endmodule

// File: tb/tb_mdu_sched.sv
module tb_mdu_sched;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mdu_sched_if bus();

  mdu_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one start pulse from a negedge; returns at the negedge one cycle later.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Count busy cycles (sampled at negedges) until busy drops, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op = 3'd0; bus.a = 32'd0; bus.b = 32'd0;
    bus.md_req = 1'b0; bus.cancel = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", bus.hi); end
    checks++; if (bus.lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 0", bus.lo); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", bus.stall); end
  endtask

  task automatic test_mult();
    int   n;
    logic hold_ok;
    issue(3'd0, 32'hFFFFFFFE, 32'd3);
    n = 0;
    hold_ok = 1'b1;
    while (bus.busy === 1'b1 && n < 40) begin
      if (bus.hi !== 32'd0 || bus.lo !== 32'd0) hold_ok = 1'b0;
      n++;
      @(negedge clk);
    end
    checks++; if (n !== 5) begin errors++; $display("FAIL mult_busy_cycles got %0d exp 5", n); end
    checks++; if (hold_ok !== 1'b1) begin errors++; $display("FAIL mult_hold got changed exp hi/lo held at 0"); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo got %h exp fffffffa", bus.lo); end
  endtask

  task automatic test_div();
    int n;
    issue(3'd3, 32'd7, 32'd2);
    wait_idle(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL divu_busy_cycles got %0d exp 10", n); end
    checks++; if (bus.lo !== 32'd3) begin errors++; $display("FAIL divu_lo got %h exp 3", bus.lo); end
    checks++; if (bus.hi !== 32'd1) begin errors++; $display("FAIL divu_hi got %h exp 1", bus.hi); end
    // issued back to back in the first idle cycle
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL div_busy_cycles got %0d exp 10", n); end
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h exp fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h exp ffffffff", bus.hi); end
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    checks++; if (bus.lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo got %h exp 80000000", bus.lo); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL div_ovf_hi got %h exp 0", bus.hi); end
  endtask

  task automatic test_mthi();
    int n;
    issue(3'd4, 32'h12345678, 32'd0);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b exp 0", bus.busy); end
    checks++; if (bus.hi !== 32'h12345678) begin errors++; $display("FAIL mthi_hi got %h exp 12345678", bus.hi); end
    checks++; if (bus.lo !== 32'h80000000) begin errors++; $display("FAIL mthi_lo got %h exp 80000000", bus.lo); end
    issue(3'd6, 32'hDEADBEEF, 32'd1);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rsvd_busy got %b exp 0", bus.busy); end
    checks++; if (bus.hi !== 32'h12345678) begin errors++; $display("FAIL rsvd_hi got %h exp 12345678", bus.hi); end
    issue(3'd5, 32'h0000ABCD, 32'd0);
    checks++; if (bus.lo !== 32'h0000ABCD) begin errors++; $display("FAIL mtlo_lo got %h exp 0000abcd", bus.lo); end
    issue(3'd3, 32'd5, 32'd0);
    wait_idle(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL div0_busy_cycles got %0d exp 10", n); end
    checks++; if (bus.hi !== 32'h12345678) begin errors++; $display("FAIL div0_hi got %h exp 12345678", bus.hi); end
    checks++; if (bus.lo !== 32'h0000ABCD) begin errors++; $display("FAIL div0_lo got %h exp 0000abcd", bus.lo); end
  endtask

  task automatic test_stall();
    logic exp_b;
    bus.md_req = 1'b1;
    bus.start  = 1'b1;
    bus.op     = 3'd1;
    bus.a      = 32'hFFFFFFFF;
    bus.b      = 32'hFFFFFFFF;
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL stall_accept got %b exp 1", bus.stall); end
    @(posedge clk);
    @(negedge clk);
    for (int k = 1; k <= 6; k++) begin
      bus.start = (k <= 5) ? 1'b1 : 1'b0;
      bus.a     = 32'd2;
      bus.b     = 32'd2;
      #1;
      exp_b = (k <= 5) ? 1'b1 : 1'b0;
      checks++; if (bus.busy !== exp_b) begin errors++; $display("FAIL stall_busy_c%0d got %b exp %b", k, bus.busy, exp_b); end
      checks++; if (bus.stall !== exp_b) begin errors++; $display("FAIL stall_c%0d got %b exp %b", k, bus.stall, exp_b); end
      @(negedge clk);
    end
    bus.md_req = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stall_restart got busy %b exp 0", bus.busy); end
    checks++; if (bus.hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h exp fffffffe", bus.hi); end
    checks++; if (bus.lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h exp 00000001", bus.lo); end
  endtask

  task automatic test_reset_mid();
    issue(3'd2, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", bus.busy); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL rstmid_hi got %h exp 0", bus.hi); end
    checks++; if (bus.lo !== 32'd0) begin errors++; $display("FAIL rstmid_lo got %h exp 0", bus.lo); end
    repeat (12) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstlate_busy got %b exp 0", bus.busy); end
    checks++; if (bus.lo !== 32'd0) begin errors++; $display("FAIL rstlate_lo got %h exp 0", bus.lo); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL rstlate_hi got %h exp 0", bus.hi); end
  endtask

  task automatic test_cancel();
    int n;
    issue(3'd5, 32'h00000055, 32'd0);
    issue(3'd0, 32'd4, 32'd5);
    @(negedge clk);
    bus.cancel = 1'b1;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL cancel_pre_busy got %b exp 1", bus.busy); end
    @(negedge clk);
    bus.cancel = 1'b0;
`ifdef MDU_CANCEL_EN
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got %b exp 0", bus.busy); end
    repeat (8) @(negedge clk);
    checks++; if (bus.lo !== 32'h00000055) begin errors++; $display("FAIL cancel_lo got %h exp 00000055", bus.lo); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL cancel_hi got %h exp 0", bus.hi); end
    bus.cancel = 1'b1;
    issue(3'd0, 32'd3, 32'd3);
    bus.cancel = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL cancel_accept_busy got %b exp 0", bus.busy); end
    checks++; if (bus.lo !== 32'h00000055) begin errors++; $display("FAIL cancel_accept_lo got %h exp 00000055", bus.lo); end
`else
    wait_idle(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL nocancel_remaining got %0d exp 3", n); end
    checks++; if (bus.lo !== 32'd20) begin errors++; $display("FAIL nocancel_lo got %h exp 00000014", bus.lo); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL nocancel_hi got %h exp 0", bus.hi); end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_mthi();
    test_stall();
    test_reset_mid();
    test_cancel();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mdu_sched.md
Name: mdu_sched

Overview:
- Multiply/divide sequencer for the pipelined MIPS core. Sits beside the ALU in the EX stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, owns the HI/LO registers and models multi-cycle latency with a busy counter.
- Raises a stall request to the hazard unit while a later HI/LO-using instruction must wait.

Parameters:
- MULT_CYCLES, 5, cycles busy is high for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, cycles busy is high for DIV/DIVU (legal range 1..15)

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  EX-stage MD instruction valid this cycle
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved
- a  in  32  rs operand
- b  in  32  rt operand
- md_req  in  1  D-stage instruction is MULT/DIV/MFHI/MFLO/MTHI/MTLO
- cancel  in  1  abort in-flight operation (active only with MDU_CANCEL_EN)
- busy  out  1  operation in progress
- stall  out  1  stall request to hazard unit
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (synchronous, active-high): hi=0, lo=0, busy=0, counter=0, state=IDLE. Reset beats every other input, including mid-operation: any pending result is discarded.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, 4-bit counter nonzero.
- Accept rule: start=1 and state=IDLE and op in 0..5, at rising edge t.
  - op 0..3: latch a, b, op. Load counter with MULT_CYCLES or DIV_CYCLES. Go to RUN. busy=1 from t+1.
  - op 4/5: hi<=a or lo<=a at edge t. Stay IDLE, busy stays 0.
  - op 6/7: no effect.
- RUN: counter decrements each edge. On the edge where counter goes 1->0:
  - write hi/lo, return to IDLE, busy=0 the following cycle.
  - Net effect: N cycles of busy=1; the result is visible on hi/lo in the first cycle busy=0.
- start while RUN: ignored. No latch, no counter reload, no hi/lo write.
- hi/lo hold their value throughout RUN. The new value appears only at completion.
- Arithmetic, all on latched operands:
  - MULT: {hi,lo} = signed 64-bit product.
  - MULTU: {hi,lo} = unsigned 64-bit product.
  - DIV: lo = signed quotient, truncated toward zero; hi = remainder, same sign as dividend.
  - DIVU: unsigned quotient and remainder.
  - DIV with 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (b=0, DIV or DIVU): still busy DIV_CYCLES, then hi/lo left unchanged.
- stall = md_req & (busy | (start & op<=3)). Purely combinational, no registered delay.
- Outputs hi, lo, busy are registered. stall is the only combinational output.

Optional Feature:
- Macro MDU_CANCEL_EN.
- Defined:
  - cancel=1 at an edge while RUN forces IDLE, counter=0, busy=0 next cycle, hi/lo unchanged.
  - cancel=1 in the same cycle as an accept: the start is dropped.
  - cancel in IDLE: no effect.
  - reset has priority over cancel.
- Undefined: the cancel port exists but is ignored; operations always run to completion.

Test Plan:
- Reset then MULT a=0xFFFFFFFE (-2), b=3 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; hi/lo stay 0 during busy.
- DIVU a=7, b=2 -> busy 10 cycles, then lo=3, hi=1. Then DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- MTHI a=0x12345678 with busy=0 -> hi=0x12345678 next cycle, busy never asserts. DIVU b=0 after it -> 10 busy cycles, hi still 0x12345678.
- MULTU start, then md_req=1 for 7 cycles with a second start each cycle -> stall=1 in the accept cycle and all 5 busy cycles, 0 after; second start ignored until IDLE; result 0xFFFFFFFF*0xFFFFFFFF gives hi=0xFFFFFFFE, lo=0x00000001.
- Reset asserted on 3rd busy cycle of DIV -> next cycle busy=0, hi=lo=0; the later completion edge produces no write.
- With MDU_CANCEL_EN: cancel on 2nd busy cycle of MULT 4*5 -> busy=0 next cycle, lo keeps prior value (not 20). Without the macro: same stimulus -> lo=20 after 5 cycles.
